mant_sub_pipe: RTL
==================

# mant_sub_pipe

Parametrised, pipelined mantissa subtractor for the floating-point adder datapath. Takes two mantissas with explicit hidden bits and produces the magnitude of their difference, an A≥B flag, a zero flag and, optionally, a leading-zero count for the normaliser. It sits between exponent alignment and normalisation, and uses a two-stage valid/ready pipeline so the adder can be back-pressured.

## Interface
- MANT_W, 10, stored mantissa width (10 = half, 23 = single, 52 = double)
- OP_W, MANT_W+1, derived operand width including the hidden bit; not to be overridden
- LZC_W, $clog2(OP_W+1), derived width of the leading-zero count
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts the pair this cycle
- mant_a, mant_b  in  MANT_W  stored mantissas
- hid_a, hid_b  in  1  hidden bits (0 for denormal/zero)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- a_ge_b  out  1  1 if {hid_a,mant_a} ≥ {hid_b,mant_b}, else 0
- mag  out  OP_W  |A−B|
- zero  out  1  mag == 0
- lzc  out  LZC_W  leading zeros of mag; OP_W when mag == 0

## Operation
- Operands: A = {hid_a,mant_a}, B = {hid_b,mant_b}, each OP_W bits, unsigned.
- Stage 1 (S1), on accept: diff = {1'b0,A} + ~{1'b0,B} + 1, computed over OP_W+1 bits.
  - Register a_ge_b = carry out of that sum (1 means A−B ≥ 0).
  - Register diff[OP_W-1:0] as the raw difference.
- Stage 2 (S2): mag = a_ge_b ? raw : (~raw + 1), truncated to OP_W bits.
  - zero = (mag == 0).
  - lzc = leading-zero count of mag.
  - All S2 outputs are registered.
- Equal operands: a_ge_b=1, mag=0, zero=1, lzc=OP_W.
- Handshake:
  - A transfer occurs on a cycle where valid && ready are both high.
  - ready2 = ~v2 | out_ready; ready1 = ~v1 | ready2; in_ready = ready1.
  - S2 loads from S1 when v1 && ready2.
  - While out_valid=1 and out_ready=0, every output holds stable.
  - out_valid does not depend combinationally on out_ready.
- Results leave in order. There is no reordering, no dropping and no duplication.

## Timing
- Latency: 2 cycles from accept to out_valid, with no stall.
- Throughput: 1 result per cycle when out_ready is held high.
- Buffering: up to 2 results are buffered. When both stages are full and out_ready=0, in_ready=0 in the same cycle.
- Simultaneous accept at input and output while full: the pipeline advances and stays full, with no bubble.
- Reset (asynchronous assert, synchronous release):
  - v1=v2=0, out_valid=0, a_ge_b=0, mag=0, zero=0, lzc=0. in_ready=1 once reset is released.
  - Reset mid-operation discards all in-flight results. Nothing is emitted afterwards for pairs accepted before reset.
- Data registers update only on stage load. Valid bits are the only state that must be reset.

## Configuration
- MANT_SUB_LZC_EN defined: S2 instantiates the leading-zero counter and lzc is driven as specified.
- MANT_SUB_LZC_EN undefined: no counter logic is built. lzc is tied to 0, and latency and handshake are unchanged.

## Structure
- Shared package mant_pkg:
  - Width helper functions for OP_W and LZC_W.
  - Half/single/double MANT_W constants (10/23/52).
  - Result struct typedef {a_ge_b, mag, zero, lzc}, reused by the normaliser.
- One sub-module, lzc_w: a parametrised, combinational, priority-style leading-zero counter (WIDTH param). It returns WIDTH for all-zero input. It is instantiated only under MANT_SUB_LZC_EN.
- The subtractor is written inline with no separate adder module.

## Test plan
- MANT_W=10, A=hid1/0x200, B=hid1/0x100, out_ready=1 → after 2 cycles: a_ge_b=1, mag=0x100, zero=0, lzc=2.
- Swapped operands (A=hid1/0x100, B=hid1/0x200) → a_ge_b=0, mag=0x100, lzc=2. Denormal A=hid0/0x001, B=hid1/0x000 → a_ge_b=0, mag=0x3FF, lzc=1.
- Equal operands hid1/0x155 both → a_ge_b=1, mag=0, zero=1, lzc=11. With MANT_SUB_LZC_EN undefined, lzc=0 and all other fields are unchanged.
- Back-pressure: offer 4 pairs back-to-back with out_ready=0.
  - Exactly 2 are accepted, then in_ready=0 and outputs hold for 5 cycles.
  - Raise out_ready → all 4 results emerge in order, 1 per cycle.
- Reset: assert rst_n=0 with both stages full → out_valid=0 immediately. After release, in_ready=1 and no stale result appears.
- MANT_W=52, random operand pairs with random valid/ready toggling (10k pairs) → every result matches the reference model |A−B|, flags and lzc, in order.

Source files
------------

// File: rtl/mant_pkg.sv
// mant_pkg -- shared definitions for the FP adder mantissa datapath.
// Contents:
//   MANT_W_HALF/SINGLE/DOUBLE : stored mantissa widths (10/23/52)
//   op_width(mant_w)          : operand width including the hidden bit
//   lzc_width(mant_w)         : width of a leading-zero count over an operand
//   mant_res_t                : subtractor result record, sized for double
//                               so the normaliser can reuse it at any width
package mant_pkg;

  localparam int unsigned MANT_W_HALF   = 10;
  localparam int unsigned MANT_W_SINGLE = 23;
  localparam int unsigned MANT_W_DOUBLE = 52;

  function automatic int unsigned op_width(input int unsigned mant_w);
    return mant_w + 1;
  endfunction

  function automatic int unsigned lzc_width(input int unsigned mant_w);
    return $clog2(mant_w + 2);
  endfunction

  typedef struct packed {
    logic                                        a_ge_b;
    logic [MANT_W_DOUBLE:0]                      mag;
    logic                                        zero;
    logic [lzc_width(MANT_W_DOUBLE)-1:0]         lzc;
  } mant_res_t;

endpackage

// File: rtl/lzc_w.sv
// lzc_w -- combinational priority leading-zero counter.
// Ports:
//   din [WIDTH-1:0]  value to scan, MSB first
//   cnt [CNT_W-1:0]  number of leading zeros; WIDTH when din is all zero
module lzc_w #(
  parameter  int unsigned WIDTH = 11,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scan from LSB upward so the highest set bit is the last one to win.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/mant_sub_pipe.sv
// mant_sub_pipe -- two-stage valid/ready mantissa subtractor.
// Produces |A-B|, A>=B, zero and (optionally) a leading-zero count, where
// A = {hid_a,mant_a} and B = {hid_b,mant_b}.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake
//   mant_a, mant_b        stored mantissas [MANT_W-1:0]
//   hid_a, hid_b          hidden bits
//   out_valid / out_ready result handshake
//   a_ge_b, mag, zero     result fields
//   lzc                   leading zeros of mag (OP_W when mag is zero)
// Build option: MANT_SUB_LZC_EN -- when defined, S2 builds the leading-zero
// counter; otherwise lzc is tied to zero.
module mant_sub_pipe
  import mant_pkg::*;
#(
  parameter  int unsigned MANT_W = MANT_W_HALF,
  localparam int unsigned OP_W   = op_width(MANT_W),
  localparam int unsigned LZC_W  = lzc_width(MANT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic              hid_a,
  input  logic              hid_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              a_ge_b,
  output logic [OP_W-1:0]   mag,
  output logic              zero,
  output logic [LZC_W-1:0]  lzc
);

  logic            v1, v2;
  logic            ready1, ready2;
  logic            ge1;
  logic [OP_W-1:0] raw1;
  logic [OP_W-1:0] op_a, op_b;
  logic [OP_W+1:0] sum;
  logic            unused_borrow;
  logic [OP_W-1:0] mag_c;

  assign ready2    = ~v2 | out_ready;
  assign ready1    = ~v1 | ready2;
  assign in_ready  = ready1;
  assign out_valid = v2;

  // Two's-complement subtract over OP_W+1 bits; bit OP_W+1 is the carry
  // out (A>=B). Bit OP_W is the borrow, always the inverse of the carry.
  always_comb begin
    op_a          = {hid_a, mant_a};
    op_b          = {hid_b, mant_b};
    sum           = {2'b00, op_a} + {1'b0, ~{1'b0, op_b}} + (OP_W + 2)'(1);
    unused_borrow = sum[OP_W];
  end

  assign mag_c = ge1 ? raw1 : (~raw1) + OP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ready1) v1 <= in_valid;
      if (ready2) v2 <= v1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ge1  <= 1'b0;
      raw1 <= '0;
    end else if (in_valid && ready1) begin
      ge1  <= sum[OP_W+1];
      raw1 <= sum[OP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ge_b <= 1'b0;
      mag    <= '0;
      zero   <= 1'b0;
    end else if (v1 && ready2) begin
      a_ge_b <= ge1;
      mag    <= mag_c;
      zero   <= (mag_c == '0);
    end
  end

`ifdef MANT_SUB_LZC_EN
  logic [LZC_W-1:0] lzc_c;
  logic [LZC_W-1:0] lzc_q;

  lzc_w #(.WIDTH(OP_W)) u_lzc (
    .din (mag_c),
    .cnt (lzc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzc_q <= '0;
    end else if (v1 && ready2) begin
      lzc_q <= lzc_c;
    end
  end

  assign lzc = lzc_q;
`else
  assign lzc = '0;
`endif

endmodule
